phase_sequencer: RTL and testbench

Top-level job controller for the ROM-to-RAM / dot-product / FIFO-transfer datapath. On a start pulse it runs one ROM-to-RAM copy, then N rounds of dot-product followed by FIFO transfer. For each phase it requests the shared resource from the three-way arbiter (r0/r1/r2 in, g0/g1/g2 out of the arbiter), launches the owning engine once granted, and releases the request on the engine's done. A per-phase watchdog aborts a hung phase and reports which phase failed.

---
 rtl/phase_sequencer.sv | 165 ++++++++++++++++
 tb/tb_phase_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Job controller: one ROM-to-RAM copy, then N rounds of dot-product followed
// by FIFO transfer. Each phase requests the shared arbiter, launches its
// engine once granted and releases the request on the engine's done. A
// per-phase watchdog aborts a hung phase and reports which phase failed.
module phase_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ITER_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ITER_W-1:0] iterations,
  output logic              r0,
  output logic              r1,
  output logic              r2,
  input  logic              g0,
  input  logic              g1,
  input  logic              g2,
  output logic              go0,
  output logic              go1,
  output logic              go2,
  input  logic              done0,
  input  logic              done1,
  input  logic              done2,
  output logic              busy,
  output logic              job_done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ITER_W-1:0] round
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  // The counter reaches TIMEOUT_CYCLES-1 on the edge where cnt_q holds this
  // value; a phase is therefore aborted on that same edge.
  localparam logic [CNT_W-1:0] EXPIRE = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    IDLE,
    REQ_COPY,
    RUN_COPY,
    REQ_DOT,
    RUN_DOT,
    REQ_XFER,
    RUN_XFER,
    FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] round_q, round_d;
  logic [2:0]        req_q, req_d;
  logic [2:0]        go_q, go_d;
  logic              busy_q, busy_d;
  logic              job_done_q, job_done_d;
  logic              error_q, error_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              in_phase;
  logic              timeout;

  // State, watchdog and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      iter_q     <= '0;
      round_q    <= '0;
      req_q      <= '0;
      go_q       <= '0;
      busy_q     <= 1'b0;
      job_done_q <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iter_q     <= iter_d;
      round_q    <= round_d;
      req_q      <= req_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      job_done_q <= job_done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
    end
  end

  // Next state: phase sequencing, with the watchdog overriding a stalled phase.
  always_comb begin
    state_d  = state_q;
    timeout  = 1'b0;
    in_phase = state_q inside {REQ_COPY, RUN_COPY, REQ_DOT, RUN_DOT, REQ_XFER, RUN_XFER};
    case (state_q)
      IDLE:     if (start) state_d = (iterations == '0) ? FINISH : REQ_COPY;
      REQ_COPY: if (g0)    state_d = RUN_COPY;
      RUN_COPY: if (done0) state_d = REQ_DOT;
      REQ_DOT:  if (g1)    state_d = RUN_DOT;
      RUN_DOT:  if (done1) state_d = REQ_XFER;
      REQ_XFER: if (g2)    state_d = RUN_XFER;
      RUN_XFER: if (done2) state_d = (round_q + ITER_W'(1) == iter_q) ? FINISH : REQ_DOT;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    // An exiting event on the expiry edge has already moved state_d on, so it wins.
    if (in_phase && (state_d == state_q) && (cnt_q == EXPIRE)) begin
      timeout = 1'b1;
      state_d = IDLE;
    end
    cnt_d = (in_phase && (state_d == state_q)) ? cnt_q + CNT_W'(1) : '0;
  end

  // Output next-values derived from the transition being taken this cycle.
  always_comb begin
    req_d      = '0;
    go_d       = '0;
    busy_d     = (state_d != IDLE);
    job_done_d = (state_q == FINISH);
    iter_d     = iter_q;
    round_d    = round_q;
    error_d    = error_q;
    err_code_d = err_code_q;

    case (state_d)
      REQ_COPY, RUN_COPY: req_d[0] = 1'b1;
      REQ_DOT,  RUN_DOT:  req_d[1] = 1'b1;
      REQ_XFER, RUN_XFER: req_d[2] = 1'b1;
      default:            req_d    = '0;
    endcase

    if (state_q == REQ_COPY && state_d == RUN_COPY) go_d[0] = 1'b1;
    if (state_q == REQ_DOT  && state_d == RUN_DOT)  go_d[1] = 1'b1;
    if (state_q == REQ_XFER && state_d == RUN_XFER) go_d[2] = 1'b1;

    if (state_q == IDLE && start) begin
      iter_d     = iterations;
      round_d    = '0;
      error_d    = 1'b0;
      err_code_d = '0;
    end

    if (state_q == RUN_XFER && done2) round_d = round_q + ITER_W'(1);

    if (timeout) begin
      error_d = 1'b1;
      case (state_q)
        REQ_COPY, RUN_COPY: err_code_d = 2'd1;
        REQ_DOT,  RUN_DOT:  err_code_d = 2'd2;
        default:            err_code_d = 2'd3;
      endcase
    end
  end

  assign r0       = req_q[0];
  assign r1       = req_q[1];
  assign r2       = req_q[2];
  assign go0      = go_q[0];
  assign go1      = go_q[1];
  assign go2      = go_q[2];
  assign busy     = busy_q;
  assign job_done = job_done_q;
  assign error    = error_q;
  assign err_code = err_code_q;
  assign round    = round_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer. The bench plays arbiter and engines;
// expected behaviour comes from a transaction-level model: the phase list
// {copy, (dot, xfer) x N}, a completed-round count and the watchdog budget.
module tb_phase_sequencer;

  localparam int TO = 16;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] iterations;
  logic          r0, r1, r2;
  logic [2:0]    gv, dv;
  logic          go0, go1, go2;
  logic          busy, job_done, error;
  logic [1:0]    err_code;
  logic [IW-1:0] round;

  int checks = 0;
  int errors = 0;
  int exp_round = 0;

  phase_sequencer #(.TIMEOUT_CYCLES(TO), .ITER_W(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .iterations(iterations),
    .r0        (r0),
    .r1        (r1),
    .r2        (r2),
    .g0        (gv[0]),
    .g1        (gv[1]),
    .g2        (gv[2]),
    .go0       (go0),
    .go1       (go1),
    .go2       (go2),
    .done0     (dv[0]),
    .done1     (dv[1]),
    .done2     (dv[2]),
    .busy      (busy),
    .job_done  (job_done),
    .error     (error),
    .err_code  (err_code),
    .round     (round)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] req();
    return {29'd0, r2, r1, r0};
  endfunction

  function automatic logic [31:0] gos();
    return {29'd0, go2, go1, go0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    gv    = '0;
    dv    = '0;
    start = 1'b0;
  endtask

  // Irrelevant activity: wrong grants/dones, start while busy, new iterations.
  task automatic noise(input int x, input bit in_run);
    gv = 3'($urandom_range(0, 7));
    dv = 3'($urandom_range(0, 7));
    if (in_run) dv[x] = 1'b0;
    else        gv[x] = 1'b0;
    start      = 1'($urandom_range(0, 1));
    iterations = IW'($urandom);
  endtask

  task automatic expect_timeout(input int x);
    chk("to_req",   req(), 0);
    chk("to_go",    gos(), 0);
    chk("to_error", 32'(error), 1);
    chk("to_code",  32'(err_code), x + 1);
    chk("to_busy",  32'(busy), 0);
    chk("to_jd",    32'(job_done), 0);
    chk("to_round", 32'(round), exp_round);
    repeat (3) begin
      tick();
      chk("to_no_jd", 32'(job_done), 0);
      chk("to_sticky", 32'(error), 1);
    end
  endtask

  // Serve one phase: grant g cycles after the request rises, done d cycles
  // after go. A delay of TO-1 is never answered in time.
  task automatic phase(input int x, input int g, input int d, input bit noisy, output bit to);
    to = 1'b0;
    chk("req_rise", req(), 1 << x);
    chk("go_low",   gos(), 0);
    for (int i = 0; i < g; i++) begin
      if (noisy) noise(x, 1'b0);
      tick();
      quiet();
      if (i == TO - 2) begin
        expect_timeout(x);
        to = 1'b1;
        return;
      end
      chk("req_hold", req(), 1 << x);
      chk("go_hold",  gos(), 0);
    end
    gv[x] = 1'b1;
    tick();
    gv = '0;
    chk("go_pulse", gos(), 1 << x);
    chk("req_run",  req(), 1 << x);
    for (int i = 0; i < d; i++) begin
      if (noisy) noise(x, 1'b1);
      tick();
      quiet();
      if (i == TO - 2) begin
        expect_timeout(x);
        to = 1'b1;
        return;
      end
      chk("req_run_hold", req(), 1 << x);
      chk("go_single",    gos(), 0);
    end
    dv[x] = 1'b1;
    tick();
    dv = '0;
    chk("req_drop", req() & (1 << x), 0);
    chk("go_after", gos(), 0);
    chk("no_error", 32'(error), 0);
  endtask

  // fail_idx selects a phase (list position) to starve; gfix/dfix < 0 = random delays.
  task automatic run_job(input int n, input bit noisy, input int fail_idx, input bit fail_run,
                         input int gfix, input int dfix);
    int phases[$];
    bit to;
    int g, d;
    phases = {};
    if (n > 0) begin
      phases.push_back(0);
      for (int k = 0; k < n; k++) begin
        phases.push_back(1);
        phases.push_back(2);
      end
    end
    exp_round  = 0;
    iterations = IW'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
    iterations = IW'($urandom);
    chk("start_busy",  32'(busy), 1);
    chk("start_err",   32'(error), 0);
    chk("start_code",  32'(err_code), 0);
    chk("start_round", 32'(round), 0);
    chk("start_jd",    32'(job_done), 0);
    if (n == 0) begin
      chk("zero_req", req(), 0);
      chk("zero_go",  gos(), 0);
      tick();
      chk("zero_jd",    32'(job_done), 1);
      chk("zero_busy",  32'(busy), 0);
      chk("zero_round", 32'(round), 0);
      chk("zero_req2",  req(), 0);
      chk("zero_go2",   gos(), 0);
      tick();
      chk("zero_jd_single", 32'(job_done), 0);
      return;
    end
    foreach (phases[p]) begin
      g = (gfix >= 0) ? gfix : int'($urandom_range(0, TO - 2));
      d = (dfix >= 0) ? dfix : int'($urandom_range(0, TO - 2));
      if (p == fail_idx) begin
        if (fail_run) d = TO - 1;
        else          g = TO - 1;
      end
      phase(phases[p], g, d, noisy, to);
      if (to) return;
      if (phases[p] == 2) exp_round++;
      chk("round", 32'(round), exp_round);
    end
    chk("fin_busy", 32'(busy), 1);
    chk("fin_req",  req(), 0);
    chk("fin_jd",   32'(job_done), 0);
    if (noisy) start = 1'b1;
    tick();
    start = 1'b0;
    chk("jd_pulse",  32'(job_done), 1);
    chk("end_busy",  32'(busy), 0);
    chk("end_round", 32'(round), n);
    chk("end_error", 32'(error), 0);
    chk("end_req",   req(), 0);
    tick();
    chk("jd_single", 32'(job_done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    bit to;
    reset      = 1'b1;
    iterations = '0;
    quiet();
    tick();
    tick();
    chk("rst_req",   req(), 0);
    chk("rst_go",    gos(), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_jd",    32'(job_done), 0);
    chk("rst_err",   32'(error), 0);
    chk("rst_code",  32'(err_code), 0);
    chk("rst_round", 32'(round), 0);
    reset = 1'b0;
    tick();

    // basic job: grant one cycle after request, done five cycles after go
    run_job(2, 1'b0, -1, 1'b0, 1, 5);
    // zero iterations
    run_job(0, 1'b0, -1, 1'b0, -1, -1);
    // dot grant withheld -> err_code 2, then a good start clears the error
    run_job(3, 1'b0, 1, 1'b0, -1, -1);
    run_job(1, 1'b0, -1, 1'b0, -1, -1);
    // copy engine hangs -> err_code 1
    run_job(2, 1'b0, 0, 1'b1, -1, -1);
    // transfer grant withheld -> err_code 3
    run_job(1, 1'b1, 2, 1'b0, -1, -1);
    // every grant and done lands on the watchdog expiry edge
    run_job(2, 1'b0, -1, 1'b0, TO - 2, TO - 2);
    // protocol noise and random delays
    for (int j = 0; j < 4; j++) run_job(int'($urandom_range(1, 4)), 1'b1, -1, 1'b0, -1, -1);

    // asynchronous reset in the middle of RUN_XFER
    exp_round  = 0;
    iterations = IW'(2);
    start      = 1'b1;
    tick();
    start = 1'b0;
    phase(0, 1, 2, 1'b0, to);
    phase(1, 0, 1, 1'b0, to);
    phase(2, 0, 3, 1'b0, to);
    chk("pre_rst_round", 32'(round), 1);
    phase(1, 2, 2, 1'b0, to);
    gv[2] = 1'b1;
    tick();
    gv = '0;
    chk("pre_rst_go2", gos(), 4);
    tick();
    chk("pre_rst_req2", req(), 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_req",   req(), 0);
    chk("arst_go",    gos(), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_round", 32'(round), 0);
    chk("arst_err",   32'(error), 0);
    chk("arst_jd",    32'(job_done), 0);
    tick();
    reset = 1'b0;
    tick();
    run_job(1, 1'b0, -1, 1'b0, -1, -1);

    // more random jobs, including a random starved phase
    for (int j = 0; j < 3; j++) run_job(int'($urandom_range(1, 3)), 1'b1,
                                        int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1, -1);
    run_job(1, 1'b1, -1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
